// File: rtl/peak_pkg.sv
// peak_pkg: shared bin geometry, bin record type and controller states for peak extraction
package peak_pkg;
    localparam int N_BINS = 512;
    localparam int IDX_W  = 9;
    localparam int MAG_W  = 16;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [MAG_W-1:0] mag;
    } bin_t;

    typedef enum logic [2:0] {
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_EMIT,
        S_MASK,
        S_DONE
    } ctrl_state_t;
endpackage

// File: rtl/bin_guard_mask.sv
// bin_guard_mask: per-bin keep mask clearing idx +/- GUARD, clipped at both ends of the bin range
module bin_guard_mask
    import peak_pkg::*;
#(
    parameter int GUARD = 2
) (
    input  logic [IDX_W-1:0]  idx_i,
    output logic [N_BINS-1:0] keep_o
);
    localparam int W = IDX_W + 2;

    logic [W-1:0] idx_w, lo, hi, sum;

    assign idx_w = {2'b00, idx_i};
    assign sum   = idx_w + W'(GUARD);
    assign lo    = (idx_w >= W'(GUARD)) ? idx_w - W'(GUARD) : '0;
    assign hi    = (sum > W'(N_BINS - 1)) ? W'(N_BINS - 1) : sum;

    for (genvar i = 0; i < N_BINS; i++) begin : g_keep
        assign keep_o[i] = (W'(i) < lo) || (W'(i) > hi);
    end
endmodule

// File: rtl/peak_extract_ctrl.sv
// peak_extract_ctrl: buffers one magnitude frame and drives the single-peak finder repeatedly,
// masking each found peak's neighbourhood until NUM_PEAKS are emitted or the finder reports none.
module peak_extract_ctrl
    import peak_pkg::*;
#(
    parameter int NUM_PEAKS = 5,
    parameter int GUARD     = 2,
    parameter int TIMEOUT   = 64
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   abort,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [MAG_W-1:0]       in_mag,
    input  logic                   in_last,
    output logic                   pf_start,
    output bin_t [N_BINS-1:0]      pf_data,
    input  bin_t                   pf_peak,
    input  logic                   pf_valid,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [IDX_W-1:0]       out_index,
    output logic [MAG_W-1:0]       out_mag,
    output logic                   out_last,
    output logic                   frame_done,
    output logic [4:0]             peaks_found,
    output logic                   frame_err
);
    localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(N_BINS - 1);

    ctrl_state_t      state_q;
    logic [IDX_W-1:0] cnt_q;
    logic [MAG_W-1:0] mag_q [N_BINS];
    logic [15:0]      tmo_q;
    logic [4:0]       peaks_q;
    logic             out_valid_q, out_last_q, frame_done_q, frame_err_q;
    logic [IDX_W-1:0] out_idx_q;
    logic [MAG_W-1:0] out_mag_q;
    logic [N_BINS-1:0] keep;
    logic [4:0]       peaks_d;

    bin_guard_mask #(.GUARD(GUARD)) u_mask (
        .idx_i  (out_idx_q),
        .keep_o (keep)
    );

    assign peaks_d     = peaks_q + 5'd1;
    assign in_ready    = state_q == S_LOAD;
    assign pf_start    = state_q == S_ISSUE;
    assign out_valid   = out_valid_q;
    assign out_index   = out_idx_q;
    assign out_mag     = out_mag_q;
    assign out_last    = out_last_q;
    assign frame_done  = frame_done_q;
    assign frame_err   = frame_err_q;
    assign peaks_found = peaks_q;

    for (genvar i = 0; i < N_BINS; i++) begin : g_data
        assign pf_data[i] = {IDX_W'(i), mag_q[i]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_LOAD;
            cnt_q        <= '0;
            tmo_q        <= '0;
            peaks_q      <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_idx_q    <= '0;
            out_mag_q    <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            for (int i = 0; i < N_BINS; i++) mag_q[i] <= '0;
        end else begin
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (abort) begin
                state_q     <= S_LOAD;
                cnt_q       <= '0;
                peaks_q     <= '0;
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_LOAD: if (in_valid) begin
                        mag_q[cnt_q] <= in_mag;
                        if (cnt_q == LAST_BIN || in_last) begin
                            cnt_q       <= '0;
                            state_q     <= S_ISSUE;
                            frame_err_q <= (cnt_q == LAST_BIN) != in_last;
                            // a short frame leaves no stale bins behind for the search
                            for (int i = 0; i < N_BINS; i++) if (i > int'(cnt_q)) mag_q[i] <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_ISSUE: begin
                        state_q <= S_WAIT;
                        tmo_q   <= '0;
                    end
                    S_WAIT: if (pf_valid && pf_peak.mag != '0) begin
                        out_valid_q <= 1'b1;
                        out_idx_q   <= pf_peak.idx;
                        out_mag_q   <= pf_peak.mag;
                        out_last_q  <= peaks_d == 5'(NUM_PEAKS);
                        state_q     <= S_EMIT;
                    end else if (pf_valid || tmo_q == 16'(TIMEOUT - 1)) begin
                        state_q      <= S_DONE;
                        frame_done_q <= 1'b1;
                        frame_err_q  <= !pf_valid;
                    end else begin
                        tmo_q <= tmo_q + 16'd1;
                    end
                    S_EMIT: if (out_ready) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        peaks_q     <= peaks_d;
                        if (peaks_d == 5'(NUM_PEAKS)) begin
                            state_q      <= S_DONE;
                            frame_done_q <= 1'b1;
                        end else begin
                            state_q <= S_MASK;
                        end
                    end
                    S_MASK: begin
                        for (int i = 0; i < N_BINS; i++) if (!keep[i]) mag_q[i] <= '0;
                        state_q <= S_ISSUE;
                    end
                    S_DONE: begin
                        state_q <= S_LOAD;
                        peaks_q <= '0;
                    end
                    default: state_q <= S_LOAD;
                endcase
            end
        end
    end
endmodule
